// File: rtl/armleocpu_csr_issuer.sv
// Execute-stage Zicsr sequencer. It turns one CSRRW/CSRRS/CSRRC instruction into
// READ and/or WRITE commands to the CSR file, then reports an rd writeback or an illegal result.
module armleocpu_csr_issuer #(
    parameter int unsigned CMD_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2:0]           instr_funct3,
    input  logic [11:0]          instr_csr_address,
    input  logic [4:0]           instr_rs1_index,
    input  logic [31:0]          instr_rs1_data,
    input  logic [4:0]           instr_rd_index,
    input  logic                 kill,
    output logic [CMD_WIDTH-1:0] csr_cmd,
    output logic [11:0]          csr_address,
    output logic [31:0]          csr_writedata,
    input  logic                 csr_invalid,
    input  logic [31:0]          csr_readdata,
    output logic                 done,
    output logic                 illegal,
    output logic                 rd_write,
    output logic [4:0]           rd_index,
    output logic [31:0]          rd_data
);

    localparam logic [CMD_WIDTH-1:0] CMD_NONE  = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_WRITE = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_READ  = CMD_WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state;
    logic        op_w;
    logic        op_s;
    logic        skip_write;
    logic [31:0] operand;
    logic [31:0] old;
    logic [4:0]  rd_q;

    logic        accept;
    logic        in_w;
    logic        in_s;
    logic [31:0] in_operand;

    assign instr_ready = (state == S_IDLE);
    assign accept      = instr_valid & instr_ready & ~kill;
    assign in_w        = (instr_funct3[1:0] == 2'b01);
    assign in_s        = (instr_funct3[1:0] == 2'b10);
    assign in_operand  = instr_funct3[2] ? {27'b0, instr_rs1_index} : instr_rs1_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            csr_cmd       <= CMD_NONE;
            csr_address   <= 12'd0;
            csr_writedata <= 32'd0;
            done          <= 1'b0;
            illegal       <= 1'b0;
            rd_write      <= 1'b0;
            rd_index      <= 5'd0;
            rd_data       <= 32'd0;
            op_w          <= 1'b0;
            op_s          <= 1'b0;
            skip_write    <= 1'b0;
            operand       <= 32'd0;
            old           <= 32'd0;
            rd_q          <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    done     <= 1'b0;
                    illegal  <= 1'b0;
                    rd_write <= 1'b0;
                    csr_cmd  <= CMD_NONE;
                    if (accept) begin
                        csr_address <= instr_csr_address;
                        rd_q        <= instr_rd_index;
                        operand     <= in_operand;
                        op_w        <= in_w;
                        op_s        <= in_s;
                        skip_write  <= ~in_w & (instr_rs1_index == 5'd0);
                        old         <= 32'd0;
                        if (instr_funct3[1:0] == 2'b00) begin
                            // Reserved funct3: report immediately, touch no CSR.
                            state    <= S_RESP;
                            done     <= 1'b1;
                            illegal  <= 1'b1;
                            rd_index <= instr_rd_index;
                            rd_data  <= 32'd0;
                        end else if (in_w && instr_rd_index == 5'd0) begin
                            state         <= S_WRITE;
                            csr_cmd       <= CMD_WRITE;
                            csr_writedata <= in_operand;
                        end else begin
                            state   <= S_READ;
                            csr_cmd <= CMD_READ;
                        end
                    end
                end
                S_READ: begin
                    if (kill) begin
                        state   <= S_IDLE;
                        csr_cmd <= CMD_NONE;
                    end else if (csr_invalid) begin
                        state    <= S_RESP;
                        csr_cmd  <= CMD_NONE;
                        done     <= 1'b1;
                        illegal  <= 1'b1;
                        rd_write <= 1'b0;
                        rd_index <= rd_q;
                        rd_data  <= old;
                    end else if (skip_write) begin
                        state    <= S_RESP;
                        csr_cmd  <= CMD_NONE;
                        done     <= 1'b1;
                        illegal  <= 1'b0;
                        rd_write <= (rd_q != 5'd0);
                        rd_index <= rd_q;
                        rd_data  <= csr_readdata;
                    end else begin
                        state   <= S_WRITE;
                        csr_cmd <= CMD_WRITE;
                        old     <= csr_readdata;
                        if (op_w)
                            csr_writedata <= operand;
                        else if (op_s)
                            csr_writedata <= csr_readdata | operand;
                        else
                            csr_writedata <= csr_readdata & ~operand;
                    end
                end
                S_WRITE: begin
                    // The CSR file commits on this edge, so kill is ignored from here on.
                    state    <= S_RESP;
                    csr_cmd  <= CMD_NONE;
                    done     <= 1'b1;
                    illegal  <= csr_invalid;
                    rd_write <= ~csr_invalid & (rd_q != 5'd0);
                    rd_index <= rd_q;
                    rd_data  <= old;
                end
                default: begin
                    state    <= S_IDLE;
                    csr_cmd  <= CMD_NONE;
                    done     <= 1'b0;
                    illegal  <= 1'b0;
                    rd_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_armleocpu_csr_issuer.sv
// Bench for armleocpu_csr_issuer: a small CSR file drives the command port and an
// instruction-level model predicts latency, command sequence, results and CSR contents.
module tb_armleocpu_csr_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_funct3;
    logic [11:0] instr_csr_address;
    logic [4:0]  instr_rs1_index;
    logic [31:0] instr_rs1_data;
    logic [4:0]  instr_rd_index;
    logic        kill;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_address;
    logic [31:0] csr_writedata;
    logic        csr_invalid;
    logic [31:0] csr_readdata;
    logic        done;
    logic        illegal;
    logic        rd_write;
    logic [4:0]  rd_index;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    armleocpu_csr_issuer #(.CMD_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_funct3(instr_funct3), .instr_csr_address(instr_csr_address),
        .instr_rs1_index(instr_rs1_index), .instr_rs1_data(instr_rs1_data),
        .instr_rd_index(instr_rd_index), .kill(kill),
        .csr_cmd(csr_cmd), .csr_address(csr_address), .csr_writedata(csr_writedata),
        .csr_invalid(csr_invalid), .csr_readdata(csr_readdata),
        .done(done), .illegal(illegal), .rd_write(rd_write),
        .rd_index(rd_index), .rd_data(rd_data)
    );

    // CSR file: mscratch/mepc read-write, 0xFC0 read-only, everything else unmapped.
    localparam logic [31:0] FC0_VAL = 32'hA5A50FC0;
    logic [31:0] f_mscratch = 32'd0;
    logic [31:0] f_mepc     = 32'd0;
    logic        f_rd_ok;
    logic        f_wr_ok;

    always_comb begin
        f_rd_ok      = 1'b1;
        f_wr_ok      = 1'b1;
        csr_readdata = 32'd0;
        case (csr_address)
            12'h340: csr_readdata = f_mscratch;
            12'h341: csr_readdata = f_mepc;
            12'hFC0: begin csr_readdata = FC0_VAL; f_wr_ok = 1'b0; end
            default: begin f_rd_ok = 1'b0; f_wr_ok = 1'b0; end
        endcase
        csr_invalid = (csr_cmd == 4'd2 && !f_rd_ok) || (csr_cmd == 4'd1 && !f_wr_ok);
    end

    always @(posedge clk) begin
        if (rst_n && csr_cmd == 4'd1 && !csr_invalid) begin
            if (csr_address == 12'h340) f_mscratch <= csr_writedata;
            if (csr_address == 12'h341) f_mepc <= csr_writedata;
        end
    end

    // Model state: expected architectural CSR contents.
    logic [31:0] m_mscratch = 32'd0;
    logic [31:0] m_mepc     = 32'd0;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction-level prediction of one Zicsr instruction against the model CSRs.
    function automatic void model(
        input  logic [2:0]  f3, input logic [11:0] addr, input logic [4:0] rs1i,
        input  logic [31:0] rs1d, input logic [4:0] rd,
        output int lat, output logic ill, output logic rdw, output logic [31:0] rdd,
        output logic [15:0] seq, output logic [31:0] wd, output logic wr);
        logic        is_w, is_s, can_rd, can_wr;
        logic [31:0] op, cur;
        is_w   = (f3[1:0] == 2'd1);
        is_s   = (f3[1:0] == 2'd2);
        op     = f3[2] ? {27'b0, rs1i} : rs1d;
        can_rd = (addr == 12'h340) || (addr == 12'h341) || (addr == 12'hFC0);
        can_wr = (addr == 12'h340) || (addr == 12'h341);
        cur    = (addr == 12'h340) ? m_mscratch : (addr == 12'h341) ? m_mepc :
                 (addr == 12'hFC0) ? FC0_VAL : 32'd0;
        lat = 1; ill = 1'b0; rdd = 32'd0; seq = 16'd0; wd = 32'd0; wr = 1'b0;
        if (f3[1:0] == 2'd0) begin
            ill = 1'b1;
        end else begin
            if (!(is_w && rd == 5'd0)) begin
                seq = {seq[11:0], 4'd2};
                lat++;
                if (!can_rd) ill = 1'b1;
                else rdd = cur;
            end
            if (!ill && !(!is_w && rs1i == 5'd0)) begin
                seq = {seq[11:0], 4'd1};
                lat++;
                wd = is_w ? op : is_s ? (cur | op) : (cur & ~op);
                if (!can_wr) ill = 1'b1;
                else wr = 1'b1;
            end
        end
        rdw = !ill && (rd != 5'd0);
    endfunction

    task automatic present(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1i,
                           input logic [31:0] rs1d, input logic [4:0] rd);
        instr_funct3      = f3;
        instr_csr_address = addr;
        instr_rs1_index   = rs1i;
        instr_rs1_data    = rs1d;
        instr_rd_index    = rd;
        instr_valid       = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic commit_model(input logic [11:0] addr, input logic [31:0] v);
        if (addr == 12'h340) m_mscratch = v;
        if (addr == 12'h341) m_mepc = v;
    endtask

    task automatic chk_mem(input string tag);
        chk({tag, " mscratch"}, f_mscratch, m_mscratch);
        chk({tag, " mepc"}, f_mepc, m_mepc);
    endtask

    task automatic run(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [4:0] rs1i, input logic [31:0] rs1d, input logic [4:0] rd);
        int          lat, n;
        logic        ill, rdw, wr;
        logic [31:0] rdd, wd, wdo;
        logic [15:0] seq, seqo;
        model(f3, addr, rs1i, rs1d, rd, lat, ill, rdw, rdd, seq, wd, wr);
        chk({tag, " ready"}, 32'(instr_ready), 32'd1);
        present(f3, addr, rs1i, rs1d, rd);
        n = 1; seqo = 16'd0; wdo = 32'd0;
        while (!done && n < 8) begin
            seqo = {seqo[11:0], csr_cmd};
            if (csr_cmd == 4'd1) wdo = csr_writedata;
            step();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " cmd_seq"}, 32'(seqo), 32'(seq));
        chk({tag, " wdata"}, wdo, wd);
        chk({tag, " cmd_at_done"}, 32'(csr_cmd), 32'd0);
        chk({tag, " illegal"}, 32'(illegal), 32'(ill));
        chk({tag, " rd_write"}, 32'(rd_write), 32'(rdw));
        chk({tag, " rd_index"}, 32'(rd_index), 32'(rd));
        if (!ill) chk({tag, " rd_data"}, rd_data, rdd);
        step();
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " ready_after"}, 32'(instr_ready), 32'd1);
        if (wr) commit_model(addr, wd);
        chk_mem(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] addrs [4];
        addrs = '{12'h340, 12'h341, 12'hFC0, 12'h7FF};
        rst_n = 1'b0; instr_valid = 1'b0; kill = 1'b0;
        instr_funct3 = 3'd0; instr_csr_address = 12'd0; instr_rs1_index = 5'd0;
        instr_rs1_data = 32'd0; instr_rd_index = 5'd0;
        step(); step();
        chk("rst cmd", 32'(csr_cmd), 32'd0);
        chk("rst addr", 32'(csr_address), 32'd0);
        chk("rst wdata", csr_writedata, 32'd0);
        chk("rst outs", {26'd0, done, illegal, rd_write, instr_ready, 2'd0}, 32'h4);
        chk("rst rd", {rd_index, rd_data[26:0]}, 32'd0);
        rst_n = 1'b1;
        step();

        run("preload", 3'b001, 12'h340, 5'd2, 32'h12345678, 5'd0);
        run("csrrw", 3'b001, 12'h340, 5'd6, 32'hDEADBEEF, 5'd5);
        chk("csrrw result", f_mscratch, 32'hDEADBEEF);
        run("csrrs_x0", 3'b010, 12'h340, 5'd0, 32'hFFFFFFFF, 5'd0);
        run("preload_ff", 3'b001, 12'h340, 5'd1, 32'h000000FF, 5'd0);
        run("csrrci", 3'b111, 12'h340, 5'h0F, $urandom, 5'd3);
        chk("csrrci result", f_mscratch, 32'h000000F0);
        run("csrrsi", 3'b110, 12'h340, 5'h01, $urandom, 5'd3);
        chk("csrrsi result", f_mscratch, 32'h000000F1);
        run("ro_write", 3'b001, 12'hFC0, 5'd2, 32'h1, 5'd1);
        run("unmapped", 3'b010, 12'h7FF, 5'd3, 32'h5, 5'd4);
        run("funct3_100", 3'b100, 12'h340, 5'd3, 32'h5, 5'd4);

        // kill while IDLE blocks accept
        instr_valid = 1'b1; kill = 1'b1; instr_funct3 = 3'b001;
        step();
        chk("kill_idle cmd", 32'(csr_cmd), 32'd0);
        chk("kill_idle ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b0; kill = 1'b0;
        step();

        // kill during READ: back to IDLE, no done, no write
        present(3'b010, 12'h340, 5'd7, 32'hFFFF0000, 5'd4);
        chk("kill_read in_read", 32'(csr_cmd), 32'd2);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_read done", 32'(done), 32'd0);
        chk("kill_read ready", 32'(instr_ready), 32'd1);
        chk("kill_read cmd", 32'(csr_cmd), 32'd0);
        step();
        chk("kill_read quiet", 32'(done), 32'd0);
        chk_mem("kill_read");

        // kill during WRITE: instruction still completes
        present(3'b001, 12'h340, 5'd9, 32'hCAFEF00D, 5'd5);
        step();
        chk("kill_write in_write", 32'(csr_cmd), 32'd1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_write done", 32'(done), 32'd1);
        chk("kill_write rd_data", rd_data, m_mscratch);
        chk("kill_write rd_write", 32'(rd_write), 32'd1);
        commit_model(12'h340, 32'hCAFEF00D);
        step();
        chk_mem("kill_write");

        for (int i = 0; i < 40; i++) begin
            logic [4:0] ri, rd;
            ri = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
            rd = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
            run($sformatf("rnd%0d", i), 3'($urandom), addrs[$urandom % 4], ri, $urandom, rd);
        end

        // reset asserted while in WRITE: command dropped, CSR untouched
        present(3'b001, 12'h340, 5'd4, 32'h55555555, 5'd5);
        step();
        chk("rst_write in_write", 32'(csr_cmd), 32'd1);
        rst_n = 1'b0;
        step();
        chk("rst_write cmd", 32'(csr_cmd), 32'd0);
        chk("rst_write addr", 32'(csr_address), 32'd0);
        chk("rst_write wdata", csr_writedata, 32'd0);
        chk("rst_write outs", {26'd0, done, illegal, rd_write, instr_ready, 2'd0}, 32'h4);
        chk("rst_write rd", {rd_index, rd_data[26:0]}, 32'd0);
        rst_n = 1'b1;
        step();
        chk_mem("rst_write");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
